uart_transceiver: RTL and testbench
===================================

# uart_transceiver

Full-duplex asynchronous serial port: an edge-triggered transmitter and an oversampling-free mid-bit receiver sharing one clock and one frame format. It sits between the fabric's parallel byte interfaces and the external RS232 pins, and is used in loopback (tx→rx) for self-test.

## Interface
- C_CLK_FRQ, 100000000: clock frequency [Hz].
- C_UART_RATE, 1000000: baud rate. DIV = C_CLK_FRQ / C_UART_RATE (integer divide), DIV ≥ 4.
- C_UART_DATA_WIDTH, 8: data bits per frame.
- C_UART_PARITY, 0: 0 = none, 1 = even parity bit after data.
- C_UART_STOP, 1: stop bits, 1 or 2.
- clk  in  1  single clock; all logic on rising edge.
- rstb  in  1  reset; synchronous, active-low.
- tx_data  in  C_UART_DATA_WIDTH  word to transmit.
- send  in  1  transmit request; rising edge triggers.
- tx_busy  out  1  transmitter frame in progress.
- tx_error  out  1  one-cycle pulse: request rejected.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous.
- rx_data  out  C_UART_DATA_WIDTH  last received word.
- rx_valid  out  1  rx_data holds unacknowledged word.
- rx_ack  in  1  consumer acknowledge.
- rx_error  out  1  one-cycle pulse: framing/parity/overrun.

## Operation
- Frame: start (0), data LSB first, optional even parity, C_UART_STOP stop bits (1); each bit DIV cycles.
- Tx FSM: IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE.
- Tx IDLE: rising edge of send (send=1, previous sample 0) latches tx_data, enters START. Level-held send never starts a second frame.
- Rising edge of send while tx_busy=1: tx_error pulse, request dropped, frame in flight unaffected.
- Rx: rx passes a 2-flop synchronizer. FSM: IDLE → START_CHK → DATA → PARITY (if enabled) → STOP → IDLE.
- IDLE: synchronized falling edge enters START_CHK; after DIV/2 cycles re-sample; high = false start → IDLE silently.
- Then sample each bit every DIV cycles (mid-bit). Only the first stop bit is checked.
- Stop sample 0 → framing error; parity mismatch → parity error; both: rx_error pulse, word discarded, rx_valid unchanged.
- Good word with rx_valid=0: load rx_data, set rx_valid. With rx_valid=1 and no rx_ack that cycle: overrun, rx_error pulse, old word kept.
- rx_ack=1 while rx_valid=1 clears rx_valid next cycle. Ack coinciding with a good word: new word loaded, rx_valid stays 1, no error.
- After stop sample, Rx returns to IDLE immediately (ready for the next falling edge).

## Timing
- Reset (rstb=0 at clk edge): tx=1, tx_busy=0, tx_error=0, rx_valid=0, rx_error=0, rx_data=0, both FSMs IDLE; mid-frame reset aborts the frame.
- Send edge sampled at cycle n: tx_busy=1 and tx=0 from cycle n+1.
- tx_busy stays high for exactly (1+W+P+S)·DIV cycles; tx=1 and tx_busy=0 afterwards. A new edge is accepted the cycle tx_busy is 0.
- Rx latency: rx_valid rises 1 cycle after the stop-bit mid sample, ≈(1+W+P+0.5)·DIV + 3 cycles after the rx falling edge.
- Error pulses last exactly 1 cycle.

## Structure
- Package uart_pkg: frame-length function, DIV computation, Tx/Rx state enums.
- Natural sub-module: uart_bit_timer (counter loaded to DIV or DIV/2, emits one-cycle tick), instantiated once in Tx and once in Rx.

## Test plan
- Reset held 10 cycles → tx=1, tx_busy=0, rx_valid=0, rx_data=0, no error pulses.
- tx_data=0xA5, send edge, 8N1, DIV=100 → tx = 0,1,0,1,0,0,1,0,1,1 for 100 cycles each; tx_busy high 1000 cycles.
- Loopback 0xA5 → rx_valid=1 with rx_data=0xA5; rx_ack 1 cycle → rx_valid=0 next cycle.
- Send re-edge during frame → tx_error 1-cycle pulse, tx waveform unchanged; send held high after frame → no second frame.
- Drive rx with stop bit 0 → rx_error pulse, rx_valid stays 0; 40-cycle low glitch → no activity.
- Two loopback words without ack → second causes rx_error, rx_data keeps first word; 200 random words with random gaps, each acked → all match.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transceiver: transmitter and receiver
// state encodings, the bit-period (DIV) computation and a frame-length
// helper.
// No ports (package).
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Clock cycles per serial bit (integer divide).
    function automatic int calc_div(input int clk_frq, input int rate);
        return clk_frq / rate;
    endfunction

    // Bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_w, input int parity, input int stop);
        return 1 + data_w + ((parity != 0) ? 1 : 0) + stop;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Bit-period timer. start_i loads the counter with DIV-1 (or DIV/2-1 when
// half_i is set) and starts it; it then emits a one-cycle tick_o every time
// the counter reaches zero and reloads itself with DIV-1, so after the first
// tick the ticks are spaced exactly one bit period apart. stop_i halts it.
// Ports:
//   clk      in   clock, rising edge
//   rstb     in   synchronous active-low reset
//   start_i  in   load and run (has priority over stop_i)
//   half_i   in   first period is DIV/2 instead of DIV
//   stop_i   in   halt the counter
//   tick_o   out  one-cycle pulse at the end of each period
module uart_bit_timer #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rstb,
    input  logic start_i,
    input  logic half_i,
    input  logic stop_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    assign tick_o = run_q && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = half_i ? HALF_LOAD : FULL_LOAD;
        end else if (stop_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = (cnt_q == '0) ? FULL_LOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver
// Full-duplex UART sharing one clock and one frame format
// (start, LSB-first data, optional even parity, 1 or 2 stop bits).
// Ports:
//   clk          in   clock, rising edge
//   rstb         in   synchronous active-low reset
//   tx_data      in   word to transmit, latched on the accepted send edge
//   send         in   transmit request, rising edge triggers
//   tx_busy      out  frame in progress
//   tx_error     out  one-cycle pulse: send edge while busy (dropped)
//   tx           out  serial output, idle high
//   rx           in   serial input, asynchronous
//   rx_data      out  last accepted word
//   rx_valid     out  rx_data holds an unacknowledged word
//   rx_ack       in   consumer acknowledge
//   rx_error     out  one-cycle pulse: framing, parity or overrun
//   tx_state_dbg out  transmitter FSM state
//   rx_state_dbg out  receiver FSM state
// Handshake: rx_valid stays high until a cycle with rx_ack=1, after which it
// drops on the next cycle unless a new good word lands in that same cycle.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int C_CLK_FRQ         = 100000000,
    parameter int C_UART_RATE       = 1000000,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_UART_PARITY     = 0,
    parameter int C_UART_STOP       = 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [C_UART_DATA_WIDTH-1:0] tx_data,
    input  logic                         send,
    output logic                         tx_busy,
    output logic                         tx_error,
    output logic                         tx,
    input  logic                         rx,
    output logic [C_UART_DATA_WIDTH-1:0] rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ack,
    output logic                         rx_error,
    output tx_state_e                    tx_state_dbg,
    output rx_state_e                    rx_state_dbg
);

    localparam int   W         = C_UART_DATA_WIDTH;
    localparam int   DIV       = calc_div(C_CLK_FRQ, C_UART_RATE);
    localparam int   BCW       = (W > 1) ? $clog2(W) : 1;
    localparam logic PARITY_EN = (C_UART_PARITY != 0);
    localparam logic STOP_LAST = (C_UART_STOP == 2);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [W-1:0]     tx_shift_q;
    logic [BCW-1:0]   tx_bit_q;
    logic             tx_par_q;
    logic             tx_stop_q;
    logic             tx_error_q;
    logic             send_q;
    logic             send_edge;
    logic             tx_tick, tx_tmr_start, tx_tmr_stop;
    logic             tx_stop_last;

    assign send_edge    = send && !send_q;
    assign tx_stop_last = (tx_stop_q == STOP_LAST);
    assign tx_error     = tx_error_q;
    assign tx_state_dbg = tx_state_q;

    uart_bit_timer #(.DIV(DIV)) u_tx_timer (
        .clk     (clk),
        .rstb    (rstb),
        .start_i (tx_tmr_start),
        .half_i  (1'b0),
        .stop_i  (tx_tmr_stop),
        .tick_o  (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstb) tx_state_q <= TX_IDLE;
        else       tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:   if (send_edge) tx_state_d = TX_START;
            TX_START:  if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA:   if (tx_tick && tx_bit_q == LAST_BIT)
                           tx_state_d = PARITY_EN ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
            TX_STOP:   if (tx_tick && tx_stop_last) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx           = 1'b1;
        tx_busy      = 1'b1;
        tx_tmr_start = 1'b0;
        tx_tmr_stop  = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_busy      = 1'b0;
                tx_tmr_start = send_edge;
            end
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift_q[0];
            TX_PARITY: tx = tx_par_q;
            TX_STOP:   tx_tmr_stop = tx_tick && tx_stop_last;
            default:   tx_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            send_q     <= 1'b0;
            tx_error_q <= 1'b0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
        end else begin
            send_q     <= send;
            tx_error_q <= send_edge && (tx_state_q != TX_IDLE);
            if (tx_state_q == TX_IDLE && send_edge) begin
                tx_shift_q <= tx_data;
                tx_par_q   <= ^tx_data;  // even parity: makes the 1-count even
                tx_bit_q   <= '0;
                tx_stop_q  <= 1'b0;
            end else if (tx_tick) begin
                if (tx_state_q == TX_DATA) begin
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= tx_bit_q + 1'b1;
                end
                if (tx_state_q == TX_STOP) tx_stop_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e        rx_state_q, rx_state_d;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic [W-1:0]     rx_shift_q;
    logic [BCW-1:0]   rx_bit_q;
    logic             rx_par_err_q;
    logic [W-1:0]     rx_data_q;
    logic             rx_valid_q;
    logic             rx_error_q;
    logic             rx_fall;
    logic             rx_tick, rx_tmr_start, rx_tmr_stop, rx_stop_evt;

    // rx_s2_q is the synchronized line; rx_s3_q only serves edge detection.
    assign rx_fall      = rx_s3_q && !rx_s2_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_error     = rx_error_q;
    assign rx_state_dbg = rx_state_q;

    uart_bit_timer #(.DIV(DIV)) u_rx_timer (
        .clk     (clk),
        .rstb    (rstb),
        .start_i (rx_tmr_start),
        .half_i  (1'b1),
        .stop_i  (rx_tmr_stop),
        .tick_o  (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstb) rx_state_q <= RX_IDLE;
        else       rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE:      if (rx_fall) rx_state_d = RX_START_CHK;
            RX_START_CHK: if (rx_tick) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_bit_q == LAST_BIT)
                              rx_state_d = PARITY_EN ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_tick) rx_state_d = RX_STOP;
            RX_STOP:      if (rx_tick) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_tmr_start = 1'b0;
        rx_tmr_stop  = 1'b0;
        rx_stop_evt  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE:      rx_tmr_start = rx_fall;
            RX_START_CHK: rx_tmr_stop  = rx_tick && rx_s2_q;  // false start
            RX_STOP: begin
                rx_tmr_stop = rx_tick;
                rx_stop_evt = rx_tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_shift_q   <= '0;
            rx_bit_q     <= '0;
            rx_par_err_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_error_q <= 1'b0;

            if (rx_state_q == RX_IDLE && rx_fall) begin
                rx_bit_q     <= '0;
                rx_par_err_q <= 1'b0;
            end
            if (rx_state_q == RX_DATA && rx_tick) begin
                rx_shift_q <= {rx_s2_q, rx_shift_q[W-1:1]};
                rx_bit_q   <= rx_bit_q + 1'b1;
            end
            if (rx_state_q == RX_PARITY && rx_tick)
                rx_par_err_q <= (rx_s2_q != ^rx_shift_q);

            if (rx_ack && rx_valid_q) rx_valid_q <= 1'b0;

            // Later assignments override the ack-clear above, so an ack in
            // the same cycle as a good word leaves rx_valid set.
            if (rx_stop_evt) begin
                if (!rx_s2_q || rx_par_err_q) begin
                    rx_error_q <= 1'b1;
                end else if (!rx_valid_q || rx_ack) begin
                    rx_data_q  <= rx_shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_error_q <= 1'b1;  // overrun: keep the unread word
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
module tb_uart_transceiver;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    // ---------------- DUT A: DIV = 100, directed ----------------
    logic [7:0] tx_data_a, rx_data_a;
    logic       send_a, tx_busy_a, tx_error_a, tx_a, rx_a;
    logic       rx_valid_a, rx_ack_a, rx_error_a;
    logic       loop_a, rx_drv_a;
    tx_state_e  tx_state_a;
    rx_state_e  rx_state_a;

    assign rx_a = loop_a ? tx_a : rx_drv_a;

    uart_transceiver #(
        .C_CLK_FRQ(100000000), .C_UART_RATE(1000000),
        .C_UART_DATA_WIDTH(8), .C_UART_PARITY(0), .C_UART_STOP(1)
    ) dut_a (
        .clk(clk), .rstb(rstb), .tx_data(tx_data_a), .send(send_a),
        .tx_busy(tx_busy_a), .tx_error(tx_error_a), .tx(tx_a), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ack(rx_ack_a),
        .rx_error(rx_error_a), .tx_state_dbg(tx_state_a), .rx_state_dbg(rx_state_a)
    );

    // ---------------- DUT B: DIV = 8, random loopback ----------------
    logic [7:0] tx_data_b, rx_data_b;
    logic       send_b, tx_busy_b, tx_error_b, tx_b;
    logic       rx_valid_b, rx_ack_b, rx_error_b;
    tx_state_e  tx_state_b;
    rx_state_e  rx_state_b;

    uart_transceiver #(
        .C_CLK_FRQ(100000000), .C_UART_RATE(12500000),
        .C_UART_DATA_WIDTH(8), .C_UART_PARITY(0), .C_UART_STOP(1)
    ) dut_b (
        .clk(clk), .rstb(rstb), .tx_data(tx_data_b), .send(send_b),
        .tx_busy(tx_busy_b), .tx_error(tx_error_b), .tx(tx_b), .rx(tx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ack(rx_ack_b),
        .rx_error(rx_error_b), .tx_state_dbg(tx_state_b), .rx_state_dbg(rx_state_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b_q[$];
    int rx_err_cnt_a = 0, tx_err_cnt_a = 0;
    int rx_err_cnt_b = 0, tx_err_cnt_b = 0, rx_cnt_b = 0;
    logic valid_prev_a = 1'b0, valid_prev_b = 1'b0;
    logic rxe_prev_a = 1'b0, txe_prev_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor A: compare every newly presented word, count error pulses.
    always @(negedge clk) begin
        if (rstb === 1'b1) begin
            if (rx_valid_a === 1'b1 && !valid_prev_a) begin
                if (exp_q.size() == 0) check("rx_a_unexpected_word", {24'd0, rx_data_a}, 32'hFFFF_FFFF);
                else                   check("rx_a_data", {24'd0, rx_data_a}, {24'd0, exp_q.pop_front()});
            end
            if (rx_error_a === 1'b1) begin
                rx_err_cnt_a++;
                check("rx_a_error_width", {31'd0, rxe_prev_a}, 0);
            end
            if (tx_error_a === 1'b1) begin
                tx_err_cnt_a++;
                check("tx_a_error_width", {31'd0, txe_prev_a}, 0);
            end
        end
        valid_prev_a = (rx_valid_a === 1'b1);
        rxe_prev_a   = (rx_error_a === 1'b1);
        txe_prev_a   = (tx_error_a === 1'b1);
    end

    // Monitor B
    always @(negedge clk) begin
        if (rstb === 1'b1) begin
            if (rx_valid_b === 1'b1 && !valid_prev_b) begin
                rx_cnt_b++;
                if (exp_b_q.size() == 0) check("rx_b_unexpected_word", {24'd0, rx_data_b}, 32'hFFFF_FFFF);
                else                     check("rx_b_data", {24'd0, rx_data_b}, {24'd0, exp_b_q.pop_front()});
            end
            if (rx_error_b === 1'b1) rx_err_cnt_b++;
            if (tx_error_b === 1'b1) tx_err_cnt_b++;
        end
        valid_prev_b = (rx_valid_b === 1'b1);
    end

    // Consumer for B: acknowledge each word after a short random delay.
    initial begin
        rx_ack_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid_b === 1'b1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                rx_ack_b = 1'b1;
                @(negedge clk);
                rx_ack_b = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tx_idle_a(input int limit);
        int n = 0;
        do begin @(negedge clk); n++; end while (tx_busy_a === 1'b1 && n < limit);
        check("tx_a_done_in_time", {31'd0, tx_busy_a}, 0);
    endtask

    task automatic tx_word_a(input logic [7:0] d);
        @(posedge clk); #1 send_a = 1'b0; tx_data_a = d;
        @(posedge clk); #1 send_a = 1'b1;
        @(posedge clk); #1 send_a = 1'b0;
        wait_tx_idle_a(1100);
    endtask

    task automatic tx_word_b(input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1 send_b = 1'b0; tx_data_b = d;
        @(posedge clk); #1 send_b = 1'b1;
        @(posedge clk); #1 send_b = 1'b0;
        do begin @(negedge clk); n++; end while (tx_busy_b === 1'b1 && n < 200);
        if (tx_busy_b === 1'b1) check("tx_b_done_in_time", {31'd0, tx_busy_b}, 0);
    endtask

    task automatic ack_a();
        @(posedge clk); #1 rx_ack_a = 1'b1;
        @(posedge clk); #1 rx_ack_a = 1'b0;
        @(negedge clk);
        check("rx_a_valid_after_ack", {31'd0, rx_valid_a}, 0);
    endtask

    // One bit period on the manual rx line of DUT A.
    task automatic rx_bit_a(input logic b);
        rx_drv_a = b;
        repeat (100) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx_a(input logic [7:0] d, input logic stop_bit);
        @(posedge clk); #1;
        rx_bit_a(1'b0);
        for (int i = 0; i < 8; i++) rx_bit_a(d[i]);
        rx_bit_a(stop_bit);
        rx_bit_a(1'b1);
    endtask

    // Called right after the clock edge that samples the send edge.
    task automatic check_tx_frame_a(input logic [9:0] frame);
        int bad_tx, bad_busy;
        for (int b = 0; b < 10; b++) begin
            bad_tx = 0;
            bad_busy = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (tx_a !== frame[b]) bad_tx++;
                if (tx_busy_a !== 1'b1) bad_busy++;
            end
            check("tx_a_bit_mismatch_cycles", bad_tx, 0);
            check("tx_a_busy_low_cycles", bad_busy, 0);
        end
        @(negedge clk);
        check("tx_a_busy_after_frame", {31'd0, tx_busy_a}, 0);
        check("tx_a_line_after_frame", {31'd0, tx_a}, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int busy_seen;
        int n;
        logic [7:0] d;
        rstb = 1'b0;
        send_a = 1'b0; tx_data_a = '0; rx_ack_a = 1'b0; loop_a = 1'b1; rx_drv_a = 1'b1;
        send_b = 1'b0; tx_data_b = '0;

        // Reset held 10 cycles.
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, tx_a}, 1);
        check("reset_tx_busy", {31'd0, tx_busy_a}, 0);
        check("reset_tx_error", {31'd0, tx_error_a}, 0);
        check("reset_rx_valid", {31'd0, rx_valid_a}, 0);
        check("reset_rx_data", {24'd0, rx_data_a}, 0);
        check("reset_rx_error", {31'd0, rx_error_a}, 0);
        check("reset_tx_state", {29'd0, tx_state_a}, {29'd0, TX_IDLE});
        check("reset_rx_state", {29'd0, rx_state_a}, {29'd0, RX_IDLE});
        @(posedge clk); #1 rstb = 1'b1;
        repeat (5) @(posedge clk);

        // 0xA5 in loopback; send re-edged mid-frame, then held high.
        #1 tx_data_a = 8'hA5; send_a = 1'b1; exp_q.push_back(8'hA5);
        @(posedge clk);
        fork
            check_tx_frame_a(10'b1_1010_0101_0);
            begin
                repeat (300) @(posedge clk); #1 send_a = 1'b0;
                repeat (10)  @(posedge clk); #1 send_a = 1'b1;
            end
        join
        busy_seen = 0;
        repeat (200) begin @(negedge clk); if (tx_busy_a !== 1'b0) busy_seen++; end
        check("tx_a_no_frame_on_held_send", busy_seen, 0);
        check("tx_a_error_pulses", tx_err_cnt_a, 1);
        check("rx_a_valid_after_loopback", {31'd0, rx_valid_a}, 1);
        check("rx_a_word_consumed", exp_q.size(), 0);
        ack_a();

        // Framing error: stop bit 0.
        loop_a = 1'b0;
        drive_rx_a(8'h5A, 1'b0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("rx_a_framing_error_pulses", rx_err_cnt_a, 1);
        check("rx_a_valid_after_framing", {31'd0, rx_valid_a}, 0);
        check("rx_a_data_kept_after_framing", {24'd0, rx_data_a}, 32'hA5);

        // 40-cycle low glitch: false start, no activity.
        @(posedge clk); #1 rx_drv_a = 1'b0;
        repeat (40) @(posedge clk); #1 rx_drv_a = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("rx_a_glitch_state", {29'd0, rx_state_a}, {29'd0, RX_IDLE});
        check("rx_a_glitch_errors", rx_err_cnt_a, 1);
        check("rx_a_glitch_valid", {31'd0, rx_valid_a}, 0);

        // Good frame on the manual line.
        exp_q.push_back(8'h3C);
        drive_rx_a(8'h3C, 1'b1);
        @(negedge clk);
        check("rx_a_manual_valid", {31'd0, rx_valid_a}, 1);
        check("rx_a_manual_consumed", exp_q.size(), 0);
        ack_a();

        // Overrun: two loopback words, no ack.
        loop_a = 1'b1;
        exp_q.push_back(8'h11);
        tx_word_a(8'h11);
        tx_word_a(8'h22);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rx_a_overrun_errors", rx_err_cnt_a, 2);
        check("rx_a_overrun_keeps_data", {24'd0, rx_data_a}, 32'h11);
        check("rx_a_overrun_valid", {31'd0, rx_valid_a}, 1);
        check("rx_a_overrun_consumed", exp_q.size(), 0);
        check("tx_a_error_pulses_final", tx_err_cnt_a, 1);
        ack_a();

        // DUT B: 200 random words with random gaps, each acked.
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_b_q.push_back(d);
            tx_word_b(d);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        n = 0;
        while (exp_b_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check("rx_b_all_consumed", exp_b_q.size(), 0);
        check("rx_b_word_count", rx_cnt_b, 200);
        check("rx_b_error_pulses", rx_err_cnt_b, 0);
        check("tx_b_error_pulses", tx_err_cnt_b, 0);
        check("rx_b_valid_idle", {31'd0, rx_valid_b}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
